// File: rtl/console_tx_packetizer.sv
// Console-to-AXI-Stream packetizer: pulls chars from a console output FIFO one read at a time
// and emits them as packets closed by newline, maximum length, idle timeout or enable drop.
module console_tx_packetizer #(
  parameter int MAX_PKT_LEN  = 256,
  parameter int IDLE_TIMEOUT = 1000,
  parameter int NL_FLUSH     = 1,
  parameter int READ_LAT     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        output_available,
  input  logic [7:0]  output_data_reg,
  output logic        output_read_en,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic [15:0] pkt_count,
  output logic        busy
);

  localparam logic [16:0] MAX_LEN  = 17'(MAX_PKT_LEN);
  localparam logic [15:0] TMO_LAST = 16'(IDLE_TIMEOUT - 1);
  localparam logic [15:0] RD_LAT   = 16'(READ_LAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SEND_HOLD,
    S_SEND_NEW,
    S_HOLD,
    S_FLUSH
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] k;
  logic [15:0] hold_timer;
  logic [15:0] wait_cnt;
  logic        hold_vld;
  logic [7:0]  hold_data;
  logic [7:0]  pend_data;

  logic        rd_en;
  logic        capture;
  logic        beat_done;
  logic        beat_load;
  logic [7:0]  beat_data;
  logic        beat_last;
  logic        hold_load;
  logic [7:0]  hold_load_data;
  logic        hold_clr;
  logic        pend_load;
  logic        timer_clr;

  // k_eff is the beat index the char would occupy in the current packet
  function automatic logic is_term(input logic [7:0] c, input logic [15:0] k_eff);
    logic [16:0] next_len;
    next_len = {1'b0, k_eff} + 17'd1;
    return (next_len == MAX_LEN) || ((NL_FLUSH != 0) && (c == 8'h0A));
  endfunction

  assign capture        = (state == S_WAIT) && (wait_cnt == RD_LAT);
  assign beat_done      = m_axis_tvalid && m_axis_tready;
  assign output_read_en = rd_en;
  assign busy           = (state != S_IDLE) || hold_vld;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    rd_en          = 1'b0;
    beat_load      = 1'b0;
    beat_data      = 8'h00;
    beat_last      = 1'b0;
    hold_load      = 1'b0;
    hold_load_data = 8'h00;
    hold_clr       = 1'b0;
    pend_load      = 1'b0;
    timer_clr      = 1'b0;
    case (state)
      S_IDLE: begin
        if (output_available && enable) begin
          rd_en     = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (capture) begin
          if (hold_vld) begin
            // held char goes out first; the new char waits in pend_data
            state_nxt = S_SEND_HOLD;
            beat_load = 1'b1;
            beat_data = hold_data;
            pend_load = 1'b1;
          end else if (is_term(output_data_reg, k)) begin
            state_nxt = S_SEND_NEW;
            beat_load = 1'b1;
            beat_data = output_data_reg;
            beat_last = 1'b1;
          end else begin
            state_nxt      = S_HOLD;
            hold_load      = 1'b1;
            hold_load_data = output_data_reg;
            timer_clr      = 1'b1;
          end
        end
      end
      S_SEND_HOLD: begin
        if (beat_done) begin
          if (is_term(pend_data, k + 16'd1)) begin
            state_nxt = S_SEND_NEW;
            beat_load = 1'b1;
            beat_data = pend_data;
            beat_last = 1'b1;
            hold_clr  = 1'b1;
          end else begin
            state_nxt      = S_HOLD;
            hold_load      = 1'b1;
            hold_load_data = pend_data;
            timer_clr      = 1'b1;
          end
        end
      end
      S_SEND_NEW: begin
        if (beat_done) begin
          state_nxt = S_IDLE;
        end
      end
      S_HOLD: begin
        // a new char wins over the timeout in the same cycle
        if (output_available && enable) begin
          rd_en     = 1'b1;
          state_nxt = S_WAIT;
        end else if (!enable || (hold_timer == TMO_LAST)) begin
          state_nxt = S_FLUSH;
          beat_load = 1'b1;
          beat_data = hold_data;
          beat_last = 1'b1;
        end
      end
      S_FLUSH: begin
        if (beat_done) begin
          hold_clr  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt      <= '0;
      hold_timer    <= '0;
      hold_vld      <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= 8'h00;
      k             <= '0;
      pkt_count     <= '0;
    end else begin
      if (rd_en) begin
        wait_cnt <= 16'd1;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + 16'd1;
      end

      if (timer_clr) begin
        hold_timer <= '0;
      end else if (state == S_HOLD) begin
        hold_timer <= hold_timer + 16'd1;
      end

      if (hold_load) begin
        hold_vld <= 1'b1;
      end else if (hold_clr) begin
        hold_vld <= 1'b0;
      end

      // a new beat may be loaded in the same cycle the previous one completes
      if (beat_load) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= beat_data;
        m_axis_tlast  <= beat_last;
      end else if (beat_done) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end

      if (beat_done) begin
        if (m_axis_tlast) begin
          k         <= '0;
          pkt_count <= pkt_count + 16'd1;
        end else begin
          k <= k + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (hold_load) begin
      hold_data <= hold_load_data;
    end
    if (pend_load) begin
      pend_data <= output_data_reg;
    end
  end

endmodule

// File: tb/tb_console_tx_packetizer.sv
// Self-checking bench for console_tx_packetizer: console FIFO model, stream monitor and a
// packetization reference model built from the char stream.
module tb_console_tx_packetizer;

  localparam int MAXL = 4;
  localparam int TMO  = 1000;
  localparam int RLAT = 2;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        output_available;
  logic [7:0]  output_data_reg;
  logic        output_read_en;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic [15:0] pkt_count;
  logic        busy;

  console_tx_packetizer #(
    .MAX_PKT_LEN (MAXL),
    .IDLE_TIMEOUT(TMO),
    .NL_FLUSH    (1),
    .READ_LAT    (RLAT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .output_available(output_available),
    .output_data_reg (output_data_reg),
    .output_read_en  (output_read_en),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tready   (m_axis_tready),
    .pkt_count       (pkt_count),
    .busy            (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_reads  = 0;
  int bad_read = 0;
  int stab_err = 0;
  int exp_pkt  = 0;
  bit rand_ready = 1'b0;

  logic [7:0] fifo[$];
  logic [7:0] due_ch[$];
  int         due_cyc[$];
  logic [7:0] obs_data[$];
  logic       obs_last[$];
  int         obs_cyc[$];
  logic [7:0] sent[$];
  logic [7:0] exp_data[$];
  logic       exp_last[$];

  logic       stall_prev = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  // Console FIFO with READ_LAT read latency, plus stream monitor sampled on the falling edge
  initial begin
    output_available = 1'b0;
    output_data_reg  = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (output_read_en) begin
          n_reads++;
          if (!(output_available && enable) || m_axis_tvalid || fifo.size() == 0) bad_read++;
          if (fifo.size() > 0) begin
            due_ch.push_back(fifo.pop_front());
            due_cyc.push_back(cyc + RLAT);
          end
        end
        if (stall_prev && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data ||
                           m_axis_tlast !== prev_last)) stab_err++;
        if (m_axis_tvalid && m_axis_tready) begin
          obs_data.push_back(m_axis_tdata);
          obs_last.push_back(m_axis_tlast);
          obs_cyc.push_back(cyc);
        end
        stall_prev = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
      end else begin
        stall_prev = 1'b0;
      end
      @(posedge clk);
      #2;
      cyc++;
      if (due_cyc.size() > 0 && due_cyc[0] == cyc) begin
        output_data_reg = due_ch.pop_front();
        void'(due_cyc.pop_front());
      end else begin
        output_data_reg = 8'($urandom);
      end
      output_available = (fifo.size() > 0);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) m_axis_tready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic push_char(input logic [7:0] c);
    fifo.push_back(c);
    sent.push_back(c);
  endtask

  task automatic clear_obs();
    obs_data.delete();
    obs_last.delete();
    obs_cyc.delete();
    sent.delete();
  endtask

  // Packet rules: close on newline, on the MAXL-th beat, or on the final char (timeout flush)
  task automatic model();
    int cnt;
    logic last;
    exp_data.delete();
    exp_last.delete();
    cnt = 0;
    foreach (sent[i]) begin
      cnt++;
      last = (sent[i] == 8'h0A) || (cnt == MAXL) || (i == sent.size() - 1);
      exp_data.push_back(sent[i]);
      exp_last.push_back(last);
      if (last) begin
        cnt = 0;
        exp_pkt++;
      end
    end
  endtask

  task automatic wait_quiet(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (fifo.size() == 0 && due_cyc.size() == 0 && !busy && !m_axis_tvalid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b1;
    m_axis_tready = 1'b1;
    tick();
    tick();
    n_checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL rst_tvalid got=%b exp=0", m_axis_tvalid); else n_pass++;
    n_checks++; if (m_axis_tlast !== 1'b0) $display("FAIL rst_tlast got=%b exp=0", m_axis_tlast); else n_pass++;
    n_checks++; if (m_axis_tdata !== 8'h00) $display("FAIL rst_tdata got=%02h exp=00", m_axis_tdata); else n_pass++;
    n_checks++; if (pkt_count !== 16'd0) $display("FAIL rst_pkt_count got=%0d exp=0", pkt_count); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (output_read_en !== 1'b0) $display("FAIL rst_read_en got=%b exp=0", output_read_en); else n_pass++;
    rst_n = 1'b1;
    exp_pkt = 0;
    tick();
  endtask

  task automatic test_newline();
    bit ok;
    clear_obs();
    push_char(8'h68);
    push_char(8'h69);
    push_char(8'h0A);
    wait_quiet(200, ok);
    n_checks++; if (!ok) $display("FAIL nl_quiet got=timeout exp=idle"); else n_pass++;
    model();
    n_checks++; if (obs_data.size() != exp_data.size()) $display("FAIL nl_beats got=%0d exp=%0d", obs_data.size(), exp_data.size()); else n_pass++;
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      n_checks++;
      if ({obs_last[i], obs_data[i]} !== {exp_last[i], exp_data[i]})
        $display("FAIL nl_beat[%0d] got last=%b data=%02h exp last=%b data=%02h", i, obs_last[i], obs_data[i], exp_last[i], exp_data[i]);
      else n_pass++;
    end
    if (obs_cyc.size() >= 3) begin
      n_checks++; if (obs_cyc[2] - obs_cyc[1] >= 10) $display("FAIL nl_no_wait got gap=%0d exp <10", obs_cyc[2] - obs_cyc[1]); else n_pass++;
    end
    n_checks++; if (pkt_count !== 16'(exp_pkt)) $display("FAIL nl_pkt_count got=%0d exp=%0d", pkt_count, exp_pkt); else n_pass++;
  endtask

  task automatic test_timeout();
    bit ok;
    clear_obs();
    push_char(8'h61);
    push_char(8'h62);
    push_char(8'h63);
    wait_quiet(2000, ok);
    n_checks++; if (!ok) $display("FAIL tmo_quiet got=timeout exp=idle"); else n_pass++;
    model();
    n_checks++; if (obs_data.size() != exp_data.size()) $display("FAIL tmo_beats got=%0d exp=%0d", obs_data.size(), exp_data.size()); else n_pass++;
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      n_checks++;
      if ({obs_last[i], obs_data[i]} !== {exp_last[i], exp_data[i]})
        $display("FAIL tmo_beat[%0d] got last=%b data=%02h exp last=%b data=%02h", i, obs_last[i], obs_data[i], exp_last[i], exp_data[i]);
      else n_pass++;
    end
    // hold is entered the cycle after 'b' completes; the flush beat follows TMO cycles later
    if (obs_cyc.size() >= 3) begin
      n_checks++; if (obs_cyc[2] - obs_cyc[1] != TMO + 1) $display("FAIL tmo_latency got=%0d exp=%0d", obs_cyc[2] - obs_cyc[1], TMO + 1); else n_pass++;
    end
    n_checks++; if (pkt_count !== 16'(exp_pkt)) $display("FAIL tmo_pkt_count got=%0d exp=%0d", pkt_count, exp_pkt); else n_pass++;
  endtask

  task automatic test_max_len();
    bit ok;
    int pkt0;
    clear_obs();
    pkt0 = exp_pkt;
    for (int i = 0; i < 10; i++) push_char(8'h41 + 8'(i));
    wait_quiet(3000, ok);
    n_checks++; if (!ok) $display("FAIL max_quiet got=timeout exp=idle"); else n_pass++;
    model();
    n_checks++; if (exp_pkt - pkt0 != 3) $display("FAIL max_model_pkts got=%0d exp=3", exp_pkt - pkt0); else n_pass++;
    n_checks++; if (obs_data.size() != exp_data.size()) $display("FAIL max_beats got=%0d exp=%0d", obs_data.size(), exp_data.size()); else n_pass++;
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      n_checks++;
      if ({obs_last[i], obs_data[i]} !== {exp_last[i], exp_data[i]})
        $display("FAIL max_beat[%0d] got last=%b data=%02h exp last=%b data=%02h", i, obs_last[i], obs_data[i], exp_last[i], exp_data[i]);
      else n_pass++;
    end
    if (obs_cyc.size() >= 8) begin
      n_checks++; if (obs_cyc[3] - obs_cyc[2] >= 8) $display("FAIL max_immediate1 got gap=%0d exp <8", obs_cyc[3] - obs_cyc[2]); else n_pass++;
      n_checks++; if (obs_cyc[7] - obs_cyc[6] >= 8) $display("FAIL max_immediate2 got gap=%0d exp <8", obs_cyc[7] - obs_cyc[6]); else n_pass++;
    end
    n_checks++; if (pkt_count !== 16'(exp_pkt)) $display("FAIL max_pkt_count got=%0d exp=%0d", pkt_count, exp_pkt); else n_pass++;
  endtask

  task automatic test_stall();
    bit ok;
    bit seen;
    int reads0;
    int stab0;
    logic [7:0] d0;
    logic l0;
    clear_obs();
    for (int i = 0; i < 6; i++) push_char(8'h6B + 8'(i));
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (m_axis_tvalid) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++; if (!seen) $display("FAIL stall_tvalid_seen got=0 exp=1"); else n_pass++;
    m_axis_tready = 1'b0;
    reads0 = n_reads;
    stab0  = stab_err;
    d0 = m_axis_tdata;
    l0 = m_axis_tlast;
    repeat (50) tick();
    n_checks++; if (m_axis_tvalid !== 1'b1) $display("FAIL stall_tvalid got=%b exp=1", m_axis_tvalid); else n_pass++;
    n_checks++; if ({m_axis_tlast, m_axis_tdata} !== {l0, d0}) $display("FAIL stall_beat got=%b/%02h exp=%b/%02h", m_axis_tlast, m_axis_tdata, l0, d0); else n_pass++;
    n_checks++; if (stab_err != stab0) $display("FAIL stall_stable got=%0d exp=%0d", stab_err, stab0); else n_pass++;
    n_checks++; if (n_reads != reads0) $display("FAIL stall_no_reads got=%0d exp=%0d", n_reads, reads0); else n_pass++;
    m_axis_tready = 1'b1;
    wait_quiet(2000, ok);
    n_checks++; if (!ok) $display("FAIL stall_quiet got=timeout exp=idle"); else n_pass++;
    model();
    n_checks++; if (obs_data.size() != exp_data.size()) $display("FAIL stall_beats got=%0d exp=%0d", obs_data.size(), exp_data.size()); else n_pass++;
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      n_checks++;
      if ({obs_last[i], obs_data[i]} !== {exp_last[i], exp_data[i]})
        $display("FAIL stall_beat[%0d] got last=%b data=%02h exp last=%b data=%02h", i, obs_last[i], obs_data[i], exp_last[i], exp_data[i]);
      else n_pass++;
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int c0;
    int reads0;
    clear_obs();
    push_char(8'h71);
    for (int i = 0; i < 50; i++) begin
      tick();
      if (fifo.size() == 0 && due_cyc.size() == 0) break;
    end
    repeat (3) tick();
    n_checks++; if (busy !== 1'b1) $display("FAIL en_busy_held got=%b exp=1", busy); else n_pass++;
    enable = 1'b0;
    c0 = cyc;
    reads0 = n_reads;
    fifo.push_back(8'h72);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (obs_data.size() > 0) break;
    end
    model();
    n_checks++; if (obs_data.size() != 1) $display("FAIL en_beats got=%0d exp=1", obs_data.size()); else n_pass++;
    if (obs_data.size() > 0) begin
      n_checks++; if ({obs_last[0], obs_data[0]} !== 9'h171) $display("FAIL en_flush_beat got=%b/%02h exp=1/71", obs_last[0], obs_data[0]); else n_pass++;
      n_checks++; if (obs_cyc[0] - c0 > 2) $display("FAIL en_flush_latency got=%0d exp<=2", obs_cyc[0] - c0); else n_pass++;
    end
    repeat (20) tick();
    n_checks++; if (n_reads != reads0) $display("FAIL en_no_reads got=%0d exp=%0d", n_reads, reads0); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL en_busy_idle got=%b exp=0", busy); else n_pass++;
    n_checks++; if (pkt_count !== 16'(exp_pkt)) $display("FAIL en_pkt_count got=%0d exp=%0d", pkt_count, exp_pkt); else n_pass++;
    enable = 1'b1;
    clear_obs();
    sent.push_back(8'h72);
    wait_quiet(1500, ok);
    n_checks++; if (!ok) $display("FAIL en_resume_quiet got=timeout exp=idle"); else n_pass++;
    model();
    n_checks++; if (obs_data.size() != exp_data.size()) $display("FAIL en_resume_beats got=%0d exp=%0d", obs_data.size(), exp_data.size()); else n_pass++;
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      n_checks++;
      if ({obs_last[i], obs_data[i]} !== {exp_last[i], exp_data[i]})
        $display("FAIL en_resume_beat[%0d] got last=%b data=%02h exp last=%b data=%02h", i, obs_last[i], obs_data[i], exp_last[i], exp_data[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0] c;
    rand_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      clear_obs();
      for (int n = 0; n < 30; n++) begin
        c = ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom_range(32, 126));
        push_char(c);
        repeat ($urandom_range(0, 4)) tick();
      end
      wait_quiet(3000, ok);
      n_checks++; if (!ok) $display("FAIL rnd%0d_quiet got=timeout exp=idle", r); else n_pass++;
      model();
      n_checks++; if (obs_data.size() != exp_data.size()) $display("FAIL rnd%0d_beats got=%0d exp=%0d", r, obs_data.size(), exp_data.size()); else n_pass++;
      for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
        n_checks++;
        if ({obs_last[i], obs_data[i]} !== {exp_last[i], exp_data[i]})
          $display("FAIL rnd%0d_beat[%0d] got last=%b data=%02h exp last=%b data=%02h", r, i, obs_last[i], obs_data[i], exp_last[i], exp_data[i]);
        else n_pass++;
      end
      n_checks++; if (pkt_count !== 16'(exp_pkt)) $display("FAIL rnd%0d_pkt_count got=%0d exp=%0d", r, pkt_count, exp_pkt); else n_pass++;
      n_checks++; if (stab_err != 0) $display("FAIL rnd%0d_stable got=%0d exp=0", r, stab_err); else n_pass++;
      n_checks++; if (bad_read != 0) $display("FAIL rnd%0d_bad_read got=%0d exp=0", r, bad_read); else n_pass++;
    end
    rand_ready = 1'b0;
    m_axis_tready = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit seen;
    int r0;
    clear_obs();
    m_axis_tready = 1'b0;
    push_char(8'h78);
    push_char(8'h79);
    push_char(8'h7A);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (m_axis_tvalid) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++; if (!seen) $display("FAIL rmid_tvalid_seen got=0 exp=1"); else n_pass++;
    tick();
    rst_n = 1'b0;
    fifo.delete();
    tick();
    n_checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL rmid_tvalid got=%b exp=0", m_axis_tvalid); else n_pass++;
    n_checks++; if (m_axis_tlast !== 1'b0) $display("FAIL rmid_tlast got=%b exp=0", m_axis_tlast); else n_pass++;
    n_checks++; if (m_axis_tdata !== 8'h00) $display("FAIL rmid_tdata got=%02h exp=00", m_axis_tdata); else n_pass++;
    n_checks++; if (pkt_count !== 16'd0) $display("FAIL rmid_pkt_count got=%0d exp=0", pkt_count); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy got=%b exp=0", busy); else n_pass++;
    rst_n = 1'b1;
    exp_pkt = 0;
    m_axis_tready = 1'b1;
    tick();
    // second reset lands while a read is in flight
    r0 = n_reads;
    push_char(8'h75);
    for (int i = 0; i < 50; i++) begin
      tick();
      if (n_reads != r0) break;
    end
    n_checks++; if (n_reads == r0) $display("FAIL rmid_read_seen got=0 exp=1"); else n_pass++;
    rst_n = 1'b0;
    fifo.delete();
    tick();
    rst_n = 1'b1;
    repeat (30) tick();
    n_checks++; if (obs_data.size() != 0) $display("FAIL rmid_no_beat got=%0d exp=0", obs_data.size()); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy_after got=%b exp=0", busy); else n_pass++;
    n_checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL rmid_tvalid_after got=%b exp=0", m_axis_tvalid); else n_pass++;
    n_checks++; if (pkt_count !== 16'd0) $display("FAIL rmid_pkt_after got=%0d exp=0", pkt_count); else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b1;
    m_axis_tready = 1'b1;
    test_reset();
    test_newline();
    test_timeout();
    test_max_len();
    test_stall();
    test_enable_drop();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/console_tx_packetizer.md
CONSOLE_TX_PACKETIZER -- requirements
Module: console_tx_packetizer

Interface
REQ-001 Parameter MAX_PKT_LEN, default 256, meaning max beats per packet (range 2..65535).
REQ-002 Parameter IDLE_TIMEOUT, default 1000, meaning cycles a held char waits in S_HOLD before it is flushed with TLAST (range 1..65535).
REQ-003 Parameter NL_FLUSH, default 1, meaning that when 1, char 0x0A terminates the packet.
REQ-004 Parameter READ_LAT, default 2, meaning cycles from an output_read_en pulse to valid output_data_reg.
REQ-005 Port clk  input  1  is the single clock; all logic is on the rising edge.
REQ-006 Port rst_n  input  1  is the reset, which is synchronous and active-low.
REQ-007 Port enable  input  1  allows new console reads when 1.
REQ-008 Port output_available  input  1  indicates the console output FIFO holds at least one char.
REQ-009 Port output_data_reg  input  8  carries the console char, valid READ_LAT cycles after output_read_en.
REQ-010 Port output_read_en  output  1  is a one-cycle read pulse to the console output FIFO.
REQ-011 Port m_axis_tdata  output  8  carries the stream byte.
REQ-012 Port m_axis_tvalid  output  1  indicates a valid stream beat.
REQ-013 Port m_axis_tlast  output  1  marks the last beat of a packet.
REQ-014 Port m_axis_tready  input  1  is downstream ready.
REQ-015 Port pkt_count  output  16  counts packets completed; it wraps at 0xFFFF to 0.
REQ-016 Port busy  output  1  is 1 whenever the FSM is not in S_IDLE.

Function
REQ-017 The FSM SHALL have the states S_IDLE, S_WAIT, S_SEND_HOLD, S_SEND_NEW, S_HOLD and S_FLUSH.
REQ-018 The block SHALL allow only one outstanding read; output_read_en SHALL pulse only in S_IDLE or S_HOLD, and only when output_available=1 and enable=1.
REQ-019 After a pulse the FSM SHALL enter S_WAIT and capture output_data_reg exactly READ_LAT cycles later as char c; output_available SHALL be ignored during S_WAIT and in the capture cycle.
REQ-020 The beat index k SHALL be the number of beats already accepted in the current packet (16 bit).
REQ-021 Char c SHALL be a terminator when (k_eff+1 == MAX_PKT_LEN) or (NL_FLUSH=1 and c == 0x0A), where k_eff counts the held char if one is present.
REQ-022 On capture with no held char: if c is a terminator, go to S_SEND_NEW with tlast=1; otherwise load c into the hold register and go to S_HOLD.
REQ-023 On capture with a held char: go to S_SEND_HOLD, presenting the held char with tlast=0 and latching c as pending; after the handshake, apply REQ-022 to c.
REQ-024 In S_HOLD, a hold timer SHALL count up from 0 on entry; output_available=1 with enable=1 SHALL take priority over the timeout in the same cycle.
REQ-025 When the hold timer reaches IDLE_TIMEOUT-1, or when enable=0 in S_HOLD, the FSM SHALL go to S_FLUSH and present the held char with tlast=1.
REQ-026 AXI-Stream rules: tdata, tvalid and tlast SHALL be held stable while tvalid=1 and tready=0; a beat completes only when tvalid=1 and tready=1; tvalid SHALL NOT depend combinationally on tready.
REQ-027 On a tlast beat handshake, k SHALL be cleared to 0, pkt_count SHALL increment, and the FSM SHALL return to S_IDLE; on a non-last beat, k SHALL increment.
REQ-028 A packet SHALL never exceed MAX_PKT_LEN beats, and a zero-length packet SHALL never be emitted.
REQ-029 enable=0 SHALL NOT abort an in-flight read or a pending beat; both SHALL complete normally.
REQ-030 busy SHALL be 0 only in S_IDLE with no held char.

Reset
REQ-031 When rst_n=0 at a clock edge, the next cycle SHALL have: state S_IDLE, output_read_en=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0x00, pkt_count=0, k=0, hold empty, timer=0, busy=0.
REQ-032 Reset mid-operation SHALL discard any held char, pending char and in-flight read data without emitting a beat.

Verification
REQ-033 Reset with tvalid high mid-packet -> next cycle tvalid=0, pkt_count=0, busy=0; the later arrival of the discarded read data produces no beat.
REQ-034 FIFO supplies 'a','b','c' then goes empty, tready=1, IDLE_TIMEOUT=1000 -> beats 0x61 and 0x62 with tlast=0, then 0x63 with tlast=1 exactly 1000 cycles after entering S_HOLD; pkt_count=1.
REQ-035 'h','i',0x0A -> the 0x0A beat has tlast=1 with no timeout wait; pkt_count increments once.
REQ-036 MAX_PKT_LEN=4, ten chars with no newline -> packets of 4, 4 and 2 beats; the 4th beat of each full packet has tlast=1 immediately; the last packet closes via timeout; pkt_count=3.
REQ-037 tready=0 for 50 cycles during a packet -> tdata, tvalid and tlast are unchanged throughout, no output_read_en pulses occur, and no bytes are lost or duplicated.
REQ-038 enable dropped while a char is held -> the held char is emitted with tlast=1 within 2 cycles, no further reads occur, and busy returns to 0.
